uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, 5208, clock cycles per bit period (50 MHz / 9600 baud); legal range >= 2.
REQ-002 SHALL have parameter DATA_BITS, 8, data bits per frame; legal range 5..8.
REQ-003 SHALL have parameter FIFO_DEPTH, 4, transmit queue entries; power of two, >= 2.
REQ-004 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port TX_DV  input  1  write strobe for TX_Byte.
REQ-007 SHALL have port TX_Byte  input  DATA_BITS  byte to queue.
REQ-008 SHALL have port TX_Ready  output  1  queue can accept a write this cycle.
REQ-009 SHALL have port PARITY_EN  input  1  1 = append parity bit.
REQ-010 SHALL have port PARITY_ODD  input  1  1 = odd parity, 0 = even.
REQ-011 SHALL have port STOP2  input  1  1 = two stop bits, 0 = one.
REQ-012 SHALL have port TX_OUT  output  1  serial line, idle high.
REQ-013 SHALL have port TX_Active  output  1  frame in progress.
REQ-014 SHALL have port TX_Done  output  1  one-cycle pulse at end of each frame.
REQ-015 SHALL have port FIFO_Count  output  $clog2(FIFO_DEPTH+1)  entries currently queued.

Function
REQ-016 SHALL drive TX_Ready = (FIFO_Count < FIFO_DEPTH), combinationally from the registered count.
REQ-017 SHALL write TX_Byte into the FIFO on any edge with TX_DV=1 and TX_Ready=1; when TX_Ready=0 the write is dropped, even if a pop occurs on the same edge.
REQ-018 SHALL pass a simultaneous write and pop with FIFO_Count unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP; every output is registered except TX_Ready.
REQ-020 IDLE: TX_OUT=1, TX_Active=0; on an edge where the FIFO is non-empty, pop the head, latch the byte plus PARITY_EN/PARITY_ODD/STOP2, and go to START.
REQ-021 SHALL ignore changes to mode inputs mid-frame; they are sampled only at the pop.
REQ-022 START: TX_OUT=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-023 DATA: send DATA_BITS bits LSB first, each held CLKS_PER_BIT cycles; after the last bit, go to PARITY if the latched PARITY_EN=1, else STOP.
REQ-024 PARITY: TX_OUT = XOR of the data bits, inverted when the latched PARITY_ODD=1, for CLKS_PER_BIT cycles, then STOP.
REQ-025 STOP: TX_OUT=1 for CLKS_PER_BIT cycles, or 2*CLKS_PER_BIT if the latched STOP2=1.
REQ-026 SHALL pulse TX_Done high for exactly one cycle, the cycle after the final stop-bit cycle.
REQ-027 At the end of STOP with the FIFO non-empty, SHALL pop and enter START directly, giving back-to-back frames with no idle cycles; otherwise return to IDLE.
REQ-028 TX_Active SHALL be 1 from the first start-bit cycle through the last stop-bit cycle, continuously across back-to-back frames.
REQ-029 Start-bit latency: TX_OUT falls on the first cycle after the popping edge, i.e. 2 cycles after the TX_DV write into an empty, idle FIFO.
REQ-030 Frame length in cycles SHALL be CLKS_PER_BIT*(1+DATA_BITS+PARITY_EN+1+STOP2).
REQ-031 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide and reset to 0 at every bit boundary.

Reset
REQ-032 When RST=1 at an edge: state=IDLE, TX_OUT=1, TX_Active=0, TX_Done=0, FIFO flushed (FIFO_Count=0, TX_Ready=1), counters=0.
REQ-033 Reset mid-frame SHALL abandon the frame with TX_OUT high on the next cycle, flush all queued bytes, and produce no TX_Done.
REQ-034 TX_DV SHALL be ignored while RST=1.

Verification (CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4)
REQ-035 Write 0xA5, no parity, 1 stop -> TX_OUT = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); one TX_Done pulse; TX_Active=0 afterwards.
REQ-036 Write 0x03 with PARITY_EN=1, PARITY_ODD=0, then 0x03 with PARITY_ODD=1 -> parity bit 0 then 1; each frame 44 cycles; the two frames are contiguous with TX_Active held high.
REQ-037 STOP2=1, write 0xFF -> stop high for 8 cycles; frame 44 cycles; TX_Done occurs 1 cycle after the 44th.
REQ-038 Write 6 bytes on consecutive cycles while idle -> 5 accepted (the first pops at once), TX_Ready drops with FIFO_Count=4, the 6th is dropped; 5 back-to-back frames are transmitted.
REQ-039 Assert RST for 1 cycle during data bit 3 with 2 bytes queued -> TX_OUT=1 on the next cycle, FIFO_Count=0, no TX_Done, line stays idle high.
REQ-040 Toggle PARITY_EN during a frame -> the frame in flight is unaffected; the next frame uses the new value.

Source files
------------

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_cfg
//  Description : Configurable UART transmitter with a small transmit FIFO.
//                Per-frame optional even/odd parity and one or two stop bits.
//                Mode inputs are captured when a byte leaves the FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               TX_DV,
    input  logic [DATA_BITS-1:0]               TX_Byte,
    output logic                               TX_Ready,
    input  logic                               PARITY_EN,
    input  logic                               PARITY_ODD,
    input  logic                               STOP2,
    output logic                               TX_OUT,
    output logic                               TX_Active,
    output logic                               TX_Done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    FIFO_Count
);

    localparam int c_cnt_w   = $clog2(CLKS_PER_BIT);
    localparam int c_bit_w   = $clog2(DATA_BITS);
    localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int c_count_w = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_cnt_w-1:0]   c_cnt_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_bit_w-1:0]   c_bit_last  = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_bit_w-1:0]   c_bit_one   = c_bit_w'(1);
    localparam logic [c_ptr_w-1:0]   c_ptr_one   = c_ptr_w'(1);
    localparam logic [c_count_w-1:0] c_count_one = c_count_w'(1);
    localparam logic [c_count_w-1:0] c_depth     = c_count_w'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_count_w-1:0] r_count;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_nempty;

    // Transmitter state
    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_bit_w-1:0]   r_bit_idx;
    logic [c_bit_w-1:0]   w_bit_nxt;
    logic                 w_bit_end;
    logic                 w_done_nxt;
    logic                 w_tx_out_nxt;
    logic                 r_tx_out;
    logic                 r_active;
    logic                 r_done;

    // Frame captured at pop time
    logic [DATA_BITS-1:0] r_data;
    logic                 r_par_en;
    logic                 r_par_odd;
    logic                 r_stop2;

    // Ready depends only on the registered count, so a full FIFO drops a
    // write even when a pop happens on the same edge.
    assign TX_Ready      = (r_count < c_depth);
    assign w_push        = TX_DV && TX_Ready && !RST;
    assign w_fifo_nempty = (r_count != '0);
    assign w_bit_end     = (r_cnt == c_cnt_last);

    assign TX_OUT     = r_tx_out;
    assign TX_Active  = r_active;
    assign TX_Done    = r_done;
    assign FIFO_Count = r_count;

    // FIFO data array write port (contents need no reset; pointers flush it)
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= TX_Byte;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_count_one;
                2'b01:   r_count <= r_count - c_count_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Next-state logic: bit timing, bit sequencing, pop and done generation
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_cnt_one;
        w_bit_nxt   = r_bit_idx;
        w_pop       = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_fifo_nempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                    w_bit_nxt   = '0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit_idx == c_bit_last) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + c_bit_one;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    // r_bit_idx counts stop bits already sent
                    if (r_stop2 && (r_bit_idx == '0)) begin
                        w_bit_nxt = c_bit_one;
                    end else begin
                        w_bit_nxt  = '0;
                        w_done_nxt = 1'b1;
                        if (w_fifo_nempty) begin
                            w_pop       = 1'b1;
                            w_state_nxt = S_START;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, derived from the next state
    always_comb begin
        w_tx_out_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_out_nxt = 1'b0;
            S_DATA:   w_tx_out_nxt = r_data[w_bit_nxt];
            S_PARITY: w_tx_out_nxt = (^r_data) ^ r_par_odd;
            default:  w_tx_out_nxt = 1'b1;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_tx_out  <= 1'b1;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_nxt;
            r_tx_out  <= w_tx_out_nxt;
            r_active  <= (w_state_nxt != S_IDLE);
            r_done    <= w_done_nxt;
        end
    end

    // Capture the head byte and the mode inputs when a frame is launched
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_stop2   <= 1'b0;
        end else if (w_pop) begin
            r_data    <= r_mem[r_rd_ptr];
            r_par_en  <= PARITY_EN;
            r_par_odd <= PARITY_ODD;
            r_stop2   <= STOP2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_cfg
//  Description : Directed self-checking bench for uart_tx_cfg
//                (CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    logic       CLK;
    logic       RST;
    logic       TX_DV;
    logic [7:0] TX_Byte;
    logic       TX_Ready;
    logic       PARITY_EN;
    logic       PARITY_ODD;
    logic       STOP2;
    logic       TX_OUT;
    logic       TX_Active;
    logic       TX_Done;
    logic [2:0] FIFO_Count;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_cfg #(
        .CLKS_PER_BIT (4),
        .DATA_BITS    (8),
        .FIFO_DEPTH   (4)
    ) u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .TX_DV      (TX_DV),
        .TX_Byte    (TX_Byte),
        .TX_Ready   (TX_Ready),
        .PARITY_EN  (PARITY_EN),
        .PARITY_ODD (PARITY_ODD),
        .STOP2      (STOP2),
        .TX_OUT     (TX_OUT),
        .TX_Active  (TX_Active),
        .TX_Done    (TX_Done),
        .FIFO_Count (FIFO_Count)
    );

    // 10 ns clock; rising edges at 5, 15, 25 ...
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Safety net against a hung run
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Repeat each time-ordered bit (MSB of 'bits' sent first) for 4 cycles
    function automatic logic [63:0] expand(input logic [15:0] bits, input int nb);
        logic [63:0] r;
        r = '0;
        for (int i = nb - 1; i >= 0; i--) begin
            for (int k = 0; k < 4; k++) begin
                r = {r[62:0], bits[i]};
            end
        end
        return r;
    endfunction

    // Starting at a negedge, queue one byte; returns at the negedge after the write edge
    task automatic write_byte(input logic [7:0] b);
        TX_Byte = b;
        TX_DV   = 1'b1;
        @(negedge CLK);
        TX_DV   = 1'b0;
    endtask

    // Sample n cycles from the current negedge. Optionally issue one write
    // (TX_Byte preset by caller) on the first cycle.
    task automatic capture(input int n, input logic wr,
                           output logic [63:0] line, output int act, output int done);
        line = '0;
        act  = 0;
        done = 0;
        for (int i = 0; i < n; i++) begin
            line = {line[62:0], TX_OUT};
            if (TX_Active) act++;
            if (i > 0 && TX_Done) done++;
            if (i == 0 && wr) TX_DV = 1'b1;
            @(negedge CLK);
            TX_DV = 1'b0;
        end
    endtask

    logic [63:0] line;
    logic [63:0] exp_line;
    int          act;
    int          done;
    int          bad;

    initial begin
        RST        = 1'b1;
        TX_DV      = 1'b0;
        TX_Byte    = 8'h00;
        PARITY_EN  = 1'b0;
        PARITY_ODD = 1'b0;
        STOP2      = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Reset state
        check("rst_tx_out",  TX_OUT,     1);
        check("rst_active",  TX_Active,  0);
        check("rst_done",    TX_Done,    0);
        check("rst_count",   FIFO_Count, 0);
        check("rst_ready",   TX_Ready,   1);

        // 0xA5, 8N1
        write_byte(8'hA5);
        check("a5_count_after_write", FIFO_Count, 1);
        check("a5_line_before_start", TX_OUT, 1);
        @(negedge CLK);
        capture(40, 1'b0, line, act, done);
        check("a5_line", line[39:0], expand(16'b0101001011, 10));
        check("a5_active_cycles", act, 40);
        check("a5_no_early_done", done, 0);
        check("a5_done_pulse", TX_Done, 1);
        check("a5_idle_after", TX_Active, 0);
        @(negedge CLK);
        check("a5_done_one_cycle", TX_Done, 0);
        check("a5_line_idle", TX_OUT, 1);

        // 0x03 even parity, then 0x03 odd parity back to back
        PARITY_EN  = 1'b1;
        PARITY_ODD = 1'b0;
        write_byte(8'h03);
        @(negedge CLK);
        PARITY_ODD = 1'b1;
        TX_Byte    = 8'h03;
        capture(44, 1'b1, line, act, done);
        check("par_even_line", line[43:0], expand(16'b01100000001, 11));
        check("par_even_active", act, 44);
        check("par_even_no_early_done", done, 0);
        check("par_even_done", TX_Done, 1);
        check("par_b2b_active", TX_Active, 1);
        check("par_b2b_start", TX_OUT, 0);
        capture(44, 1'b0, line, act, done);
        check("par_odd_line", line[43:0], expand(16'b01100000011, 11));
        check("par_odd_active", act, 44);
        check("par_odd_done", TX_Done, 1);
        check("par_odd_idle_after", TX_Active, 0);
        PARITY_EN  = 1'b0;
        PARITY_ODD = 1'b0;
        @(negedge CLK);

        // 0xFF with two stop bits
        STOP2 = 1'b1;
        write_byte(8'hFF);
        @(negedge CLK);
        STOP2 = 1'b0;
        capture(44, 1'b0, line, act, done);
        check("stop2_line", line[43:0], expand(16'b01111111111, 11));
        check("stop2_active", act, 44);
        check("stop2_no_early_done", done, 0);
        check("stop2_done", TX_Done, 1);
        @(negedge CLK);

        // Six consecutive writes while idle: first pops at once, sixth dropped
        for (int k = 0; k < 6; k++) begin
            TX_Byte = 8'h11 * (k + 1);
            TX_DV   = 1'b1;
            @(negedge CLK);
            if (k == 1) check("burst_start_bit", TX_OUT, 0);
            if (k == 4) begin
                check("burst_full_count", FIFO_Count, 4);
                check("burst_full_ready", TX_Ready, 0);
            end
        end
        TX_DV = 1'b0;
        check("burst_drop_count", FIFO_Count, 4);
        capture(36, 1'b0, line, act, done);
        exp_line = expand(16'b0100010001, 10);
        check("burst_f1_line", line[35:0], exp_line[35:0]);
        check("burst_f1_done", TX_Done, 1);
        check("burst_count_after_pop", FIFO_Count, 3);
        capture(40, 1'b0, line, act, done);
        check("burst_f2_line", line[39:0], expand(16'b0010001001, 10));
        check("burst_f2_active", act, 40);
        capture(40, 1'b0, line, act, done);
        check("burst_f3_line", line[39:0], expand(16'b0110011001, 10));
        capture(40, 1'b0, line, act, done);
        check("burst_f4_line", line[39:0], expand(16'b0001000101, 10));
        capture(40, 1'b0, line, act, done);
        check("burst_f5_line", line[39:0], expand(16'b0101010101, 10));
        check("burst_f5_done", TX_Done, 1);
        check("burst_f5_idle", TX_Active, 0);
        check("burst_empty", FIFO_Count, 0);
        repeat (3) @(negedge CLK);
        check("burst_sixth_dropped", TX_Active, 0);

        // Reset during data bit 3 with two bytes queued; TX_DV held during reset
        for (int k = 0; k < 3; k++) begin
            TX_Byte = 8'h00;
            TX_DV   = 1'b1;
            @(negedge CLK);
        end
        TX_DV = 1'b0;
        check("rstmid_queued", FIFO_Count, 2);
        repeat (16) @(negedge CLK);
        check("rstmid_bit3_low", TX_OUT, 0);
        RST     = 1'b1;
        TX_DV   = 1'b1;
        TX_Byte = 8'h5A;
        @(negedge CLK);
        RST   = 1'b0;
        TX_DV = 1'b0;
        check("rstmid_line_high", TX_OUT, 1);
        check("rstmid_flushed", FIFO_Count, 0);
        check("rstmid_ready", TX_Ready, 1);
        check("rstmid_inactive", TX_Active, 0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (!TX_OUT || TX_Done || TX_Active) bad++;
            @(negedge CLK);
        end
        check("rstmid_stays_idle", bad, 0);

        // Parity enable changed mid-frame only affects the next frame
        PARITY_EN = 1'b0;
        write_byte(8'h03);
        @(negedge CLK);
        PARITY_EN = 1'b1;
        TX_Byte   = 8'h03;
        capture(40, 1'b1, line, act, done);
        check("modechg_f1_line", line[39:0], expand(16'b0110000001, 10));
        check("modechg_f1_active", act, 40);
        check("modechg_f1_done", TX_Done, 1);
        capture(44, 1'b0, line, act, done);
        check("modechg_f2_line", line[43:0], expand(16'b01100000001, 11));
        check("modechg_f2_done", TX_Done, 1);
        PARITY_EN = 1'b0;
        @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
